// File: rtl/alu_exec_unit.sv
// Registered ALU with a handshake interface. Shifts run one bit per cycle;
// all other operations complete at the accept edge.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_EQ   = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_op;
    logic [SHAMT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0]   r_work;

    logic [SHAMT_WIDTH-1:0]  w_shamt;
    logic                    w_start_shift;
    logic                    w_last_shift;
    logic [DATA_WIDTH-1:0]   w_comb_result;
    logic [DATA_WIDTH-1:0]   w_shift_step;

    assign w_shamt       = SrcB[SHAMT_WIDTH-1:0];
    assign w_start_shift = (Operation inside {OP_SLL, OP_SRL, OP_SRA}) && (w_shamt != '0);
    assign w_last_shift  = (r_cnt == SHAMT_WIDTH'(1));

    // Shift ops reach here only with a zero shift amount, so they pass SrcA through.
    always_comb begin
        w_comb_result = '0;
        case (Operation)
            OP_AND:  w_comb_result = SrcA & SrcB;
            OP_SUB:  w_comb_result = SrcA - SrcB;
            OP_ADD:  w_comb_result = SrcA + SrcB;
            OP_OR:   w_comb_result = SrcA | SrcB;
            OP_XOR:  w_comb_result = SrcA ^ SrcB;
            OP_SLL, OP_SRL, OP_SRA: w_comb_result = SrcA;
            OP_EQ:   w_comb_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            OP_SLT:  w_comb_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: w_comb_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
            default: w_comb_result = '0;
        endcase
    end

    always_comb begin
        w_shift_step = r_work;
        case (r_op)
            OP_SLL:  w_shift_step = {r_work[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  w_shift_step = {1'b0, r_work[DATA_WIDTH-1:1]};
            OP_SRA:  w_shift_step = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
            default: w_shift_step = r_work;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_start_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (w_last_shift) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Result registers only change at an accept edge or the final shift edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= '0;
            r_cnt     <= '0;
            r_work    <= '0;
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op <= Operation;
                        if (w_start_shift) begin
                            r_work <= SrcA;
                            r_cnt  <= w_shamt;
                        end else begin
                            ALUResult <= w_comb_result;
                            Zero      <= (w_comb_result == '0);
                        end
                    end
                end
                SHIFT: begin
                    r_work <= w_shift_step;
                    r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
                    if (w_last_shift) begin
                        ALUResult <= w_shift_step;
                        Zero      <= (w_shift_step == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int DW = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [3:0]    Operation = '0;
    logic [DW-1:0] SrcA = '0;
    logic [DW-1:0] SrcB = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] ALUResult;
    logic          Zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
        .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [SW-1:0] sh_bits;
        int sh;
        sh_bits = b[SW-1:0];
        sh = int'(sh_bits);
        case (op)
            4'd0:    ref_result = a & b;
            4'd1:    ref_result = a - b;
            4'd2:    ref_result = a + b;
            4'd3:    ref_result = a | b;
            4'd4:    ref_result = a ^ b;
            4'd5:    ref_result = a << sh;
            4'd6:    ref_result = a >> sh;
            4'd7:    ref_result = $signed(a) >>> sh;
            4'd8:    ref_result = (a == b) ? 32'd1 : 32'd0;
            4'd9:    ref_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10:   ref_result = (a < b) ? 32'd1 : 32'd0;
            default: ref_result = 32'd0;
        endcase
    endfunction

    // Rising edges after the accept edge before out_valid is seen.
    function automatic int ref_latency(input logic [3:0] op, input logic [DW-1:0] b);
        logic [SW-1:0] sh_bits;
        sh_bits = b[SW-1:0];
        if (op == 4'd5 || op == 4'd6 || op == 4'd7) ref_latency = int'(sh_bits);
        else ref_latency = 0;
    endfunction

    // Issue one operation, wait for the result, hold it for `hold` cycles, then consume it.
    task automatic do_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
        logic [DW-1:0] exp_r;
        logic          exp_z;
        int            exp_lat;
        int            edges;
        exp_r   = ref_result(op, a, b);
        exp_z   = (exp_r == '0);
        exp_lat = ref_latency(op, b);

        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_ready op=%0d: in_ready=%b expected 1", op, in_ready);
        end
        in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;

        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_ready op=%0d edge=%0d: in_ready=%b expected 0", op, edges, in_ready);
            end
            @(posedge clk); #1;
            edges++;
        end

        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL out_valid op=%0d: out_valid=%b expected 1 (timeout)", op, out_valid);
        end
        n_checks++;
        if (edges !== exp_lat) begin
            n_errors++;
            $display("FAIL latency op=%0d a=%h b=%h: %0d edges expected %0d", op, a, b, edges, exp_lat);
        end
        n_checks++;
        if (ALUResult !== exp_r) begin
            n_errors++;
            $display("FAIL result op=%0d a=%h b=%h: got %h expected %h", op, a, b, ALUResult, exp_r);
        end
        n_checks++;
        if (Zero !== exp_z) begin
            n_errors++;
            $display("FAIL zero op=%0d a=%h b=%h: got %b expected %b", op, a, b, Zero, exp_z);
        end

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== exp_r || Zero !== exp_z) begin
                n_errors++;
                $display("FAIL hold op=%0d cycle=%0d: out_valid=%b in_ready=%b result=%h zero=%b expected 1 0 %h %b",
                         op, i, out_valid, in_ready, ALUResult, Zero, exp_r, exp_z);
            end
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL handshake op=%0d: out_valid=%b in_ready=%b expected 0 1", op, out_valid, in_ready);
        end
        n_checks++;
        if (ALUResult !== exp_r || Zero !== exp_z) begin
            n_errors++;
            $display("FAIL retain op=%0d: result=%h zero=%b expected %h %b", op, ALUResult, Zero, exp_r, exp_z);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #12;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        n_checks++;
        if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_data: result=%h zero=%b expected 00000000 1", ALUResult, Zero);
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_directed;
        do_op(4'd2, 32'hFFFFFFFF, 32'h00000001, 0);
        do_op(4'd7, 32'h80000000, 32'h0000001F, 0);
        do_op(4'd9, 32'hFFFFFFFE, 32'h00000001, 0);
        do_op(4'd10, 32'hFFFFFFFE, 32'h00000001, 0);
        do_op(4'd1, 32'd5, 32'd7, 4);
        do_op(4'd15, 32'h12345678, 32'h9ABCDEF0, 1);
        do_op(4'd11, 32'hDEADBEEF, 32'h00000000, 0);
        do_op(4'd8, 32'hCAFEF00D, 32'hCAFEF00D, 0);
    endtask

    task automatic test_shift_edges;
        do_op(4'd5, 32'hA5A5A5A5, 32'h00000000, 0);
        do_op(4'd6, 32'hF0000001, 32'hFFFFFFE3, 1);
        do_op(4'd5, 32'h00000001, 32'h0000001F, 0);
        do_op(4'd6, 32'h80000000, 32'h0000001F, 0);
        do_op(4'd7, 32'h7FFFFFFF, 32'h00000001, 2);
        do_op(4'd5, 32'h00000003, 32'h0000001F, 0);
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        in_valid = 1'b1; Operation = 4'd2; SrcA = a1; SrcB = b1;
        @(posedge clk); #1;
        Operation = 4'd4; SrcA = a2; SrcB = b2; out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || ALUResult !== a1 + b1) begin
            n_errors++;
            $display("FAIL b2b_first: out_valid=%b result=%h expected 1 %h", out_valid, ALUResult, a1 + b1);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== a1 + b1) begin
            n_errors++;
            $display("FAIL b2b_no_accept: out_valid=%b in_ready=%b result=%h expected 0 1 %h",
                     out_valid, in_ready, ALUResult, a1 + b1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || ALUResult !== (a2 ^ b2)) begin
            n_errors++;
            $display("FAIL b2b_second: out_valid=%b result=%h expected 1 %h", out_valid, ALUResult, a2 ^ b2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort;
        int seen;
        in_valid = 1'b1; Operation = 4'd5; SrcA = 32'h00000001; SrcB = 32'h00000010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_busy: out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_reset: out_valid=%b result=%h zero=%b expected 0 00000000 1",
                     out_valid, ALUResult, Zero);
        end
        #2 reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL abort_release: %0d cycles with out_valid/in_ready wrong, expected 0", seen);
        end
        n_checks++;
        if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_retain: result=%h zero=%b expected 00000000 1", ALUResult, Zero);
        end
    endtask

    task automatic test_random;
        logic [3:0]    op;
        logic [DW-1:0] a, b;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = '0;
            if ($urandom_range(0, 3) == 0) b = a;
            do_op(op, a, b, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_shift_edges();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001: Parameter DATA_WIDTH, default 32, operand and result width.
REQ-002: Parameter SHAMT_WIDTH, default 5, shift-amount width taken from SrcB[SHAMT_WIDTH-1:0].
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately.
REQ-005: in_valid  input  1  upstream offers Operation/SrcA/SrcB.
REQ-006: in_ready  output  1  unit accepts a new operation.
REQ-007: Operation  input  4  ALU operation code from the ALU controller.
REQ-008: SrcA  input  DATA_WIDTH  first operand.
REQ-009: SrcB  input  DATA_WIDTH  second operand, or shift amount in its low bits.
REQ-010: out_valid  output  1  ALUResult/Zero hold a completed result.
REQ-011: out_ready  input  1  downstream consumes the result.
REQ-012: ALUResult  output  DATA_WIDTH  registered result.
REQ-013: Zero  output  1  registered flag, 1 when ALUResult == 0.

Function
REQ-014: Operation encoding SHALL be: 0000 AND, 0001 SUB, 0010 ADD, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 EQ, 1001 SLT, 1010 SLTU; 1011-1111 undefined.
REQ-015: EQ/SLT/SLTU SHALL produce 1 or 0 in bit 0, upper bits zero; SLT signed, SLTU unsigned.
REQ-016: ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; no overflow output.
REQ-017: Undefined codes SHALL produce ALUResult=0, Zero=1, single-cycle latency.
REQ-018: FSM states SHALL be IDLE, SHIFT, DONE.
REQ-019: in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-020: Accept occurs on a rising edge with state IDLE and in_valid=1; Operation, SrcA, SrcB SHALL be sampled only then and ignored otherwise.
REQ-021: Non-shift op, or shift with shamt=0: result written at the accept edge, IDLE->DONE; out_valid high the next cycle (latency 1).
REQ-022: Shift with shamt=N>0: accept edge loads work register=SrcA, counter=N, IDLE->SHIFT.
REQ-023: In SHIFT, each edge SHALL shift work register one bit (SLL: zero-fill from LSB; SRL: zero-fill from MSB; SRA: replicate MSB) and decrement counter.
REQ-024: The SHIFT edge where counter==1 SHALL write final value to ALUResult/Zero and move to DONE; out_valid asserts N cycles after accept (N=31 -> 31 cycles).
REQ-025: In DONE, ALUResult/Zero SHALL stay stable while out_ready=0; on edge with out_ready=1, DONE->IDLE.
REQ-026: After handshake, ALUResult/Zero SHALL retain last value until next result is written.
REQ-027: No new accept in the same cycle as a result handshake; minimum issue interval is 2 cycles.
REQ-028: SrcB bits above SHAMT_WIDTH SHALL be ignored for shifts.

Reset
REQ-029: reset=0 SHALL, asynchronously, force state=IDLE, counter=0, work register=0, ALUResult=0, Zero=1, out_valid=0, in_ready=1 after release.
REQ-030: Reset during SHIFT or DONE SHALL abandon the operation; no result delivered after release.
REQ-031: First accept possible on the first rising edge after reset returns to 1.

Verification
REQ-032: ADD SrcA=0xFFFFFFFF SrcB=0x00000001, out_ready=1 -> out_valid 1 cycle after accept, ALUResult=0x00000000, Zero=1.
REQ-033: SRA SrcA=0x80000000 SrcB=0x0000001F -> out_valid 31 cycles after accept, ALUResult=0xFFFFFFFF, Zero=0; in_ready=0 throughout.
REQ-034: SLT SrcA=0xFFFFFFFE SrcB=0x00000001 -> 0x00000001; SLTU same operands -> 0x00000000, Zero=1.
REQ-035: SUB SrcA=5 SrcB=7 with out_ready=0 for 4 cycles -> ALUResult=0xFFFFFFFE held stable, out_valid held, in_ready=0 until handshake.
REQ-036: SLL SrcA=0x00000001 SrcB=0x00000010, reset pulsed low at 8th cycle after accept -> out_valid=0, ALUResult=0, Zero=1; no output after release.
REQ-037: Operation=1111 SrcA=0x12345678 -> ALUResult=0x00000000, Zero=1, latency 1.
